// File: rtl/bocks_pkg.sv
// Shared constants for the framebuffer upload path: geometry, threshold, FSM encoding.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package bocks_pkg;

    localparam int unsigned DEF_PIXEL_COUNT = 307200;
    localparam int unsigned PIXEL_WIDTH     = 8;
    localparam logic [7:0]  DEF_THRESHOLD   = 8'h80;
    localparam int unsigned PIXELS_PER_BYTE = 8;
    localparam int unsigned DEF_BYTE_COUNT  = DEF_PIXEL_COUNT / PIXELS_PER_BYTE;

    // 1 bpp bit order matches the font bitmaps: the leftmost pixel lands in bit 7.
    localparam int unsigned LEFTMOST_BIT    = 7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Unsigned pix >= thr via the borrow of a widened subtract, so a zero threshold is not a constant compare.
    function automatic logic pixel_on(input logic [PIXEL_WIDTH-1:0] pix,
                                      input logic [PIXEL_WIDTH-1:0] thr);
        logic [PIXEL_WIDTH:0] diff;
        diff = {1'b0, pix} - {1'b0, thr};
        return ~diff[PIXEL_WIDTH];
    endfunction

endpackage

// File: rtl/fb_upload_packer_packer.sv
// Thresholds incoming pixels to 1 bpp and shifts them in from the LSB side.
// Latency: one capture per cycle; o_done flags the cycle the 8th pixel is being captured.
// Backpressure: none, captures whenever i_cap is high; i_clear wins over i_cap.
module fb_pixel_packer
    import bocks_pkg::*;
#(
    parameter logic [7:0] THRESHOLD = DEF_THRESHOLD
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_cap,
    input  logic [PIXEL_WIDTH-1:0] i_pix,
    output logic [7:0]             o_next,
    output logic                   o_done
);

    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic       w_bit;

    assign w_bit  = pixel_on(i_pix, THRESHOLD);
    assign o_next = {r_shift[LEFTMOST_BIT-1:0], w_bit};
    assign o_done = i_cap && (r_cnt == 3'(PIXELS_PER_BYTE - 1));

    always_ff @(posedge pclk) begin
        if (reset || i_clear) begin
            r_shift <= 8'h00;
            r_cnt   <= 3'd0;
        end else if (i_cap) begin
            r_shift <= o_next;
            r_cnt   <= r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/fb_upload_packer.sv
// Serves HPS ioctl upload reads by fetching 8 framebuffer pixels and packing them 1 bpp (bit 7 = leftmost).
// Latency: wait high 9 cycles, byte on the 10th; out-of-range in 2. FB_UPLOAD_PREFETCH_EN adds next-byte prefetch.
// Backpressure: ioctl_wait holds the HPS off; requests outside IDLE are ignored, upload fall aborts.
module fb_upload_packer
    import bocks_pkg::*;
#(
    parameter int unsigned PIXEL_COUNT = DEF_PIXEL_COUNT,
    parameter logic [7:0]  THRESHOLD   = DEF_THRESHOLD
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic                   ioctl_upload,
    input  logic                   ioctl_rd,
    input  logic [26:0]            ioctl_addr,
    output logic [7:0]             ioctl_din,
    output logic                   ioctl_wait,
    output logic                   fb_rd,
    output logic [31:0]            fb_addr,
    input  logic [PIXEL_WIDTH-1:0] fb_data
);

    localparam logic [27:0] BYTE_COUNT = 28'(PIXEL_COUNT / PIXELS_PER_BYTE);

    logic [1:0]  r_state;
    logic [2:0]  r_k;
    logic        r_fb_rd, r_cap, r_wait;
    logic [31:0] r_fb_addr;
    logic [7:0]  r_din, r_resp;
    logic        w_req, w_in_range, w_pk_clear, w_pk_done;
    logic [31:0] w_base;
    logic [7:0]  w_pk_next;
`ifdef FB_UPLOAD_PREFETCH_EN
    logic        r_pf_run, r_pf_claim, r_pf_valid;
    logic [7:0]  r_pf_byte;
    logic [26:0] r_cur_addr;
    logic        w_claim, w_restart, w_next_ok;
    logic [27:0] w_next_addr;
`endif

    always_comb begin
        w_req      = ioctl_upload & ioctl_rd;
        w_in_range = {1'b0, ioctl_addr} < BYTE_COUNT;
        w_base     = {2'b00, ioctl_addr, 3'b000};
        w_pk_clear = (r_state == S_IDLE) || (r_state == S_RESP);
`ifdef FB_UPLOAD_PREFETCH_EN
        w_next_addr = {1'b0, r_cur_addr} + 28'd1;
        w_next_ok   = w_next_addr < BYTE_COUNT;
        w_claim     = r_pf_run & ~r_pf_claim & w_req & (ioctl_addr == r_cur_addr);
        w_restart   = r_pf_run & ~r_pf_claim & w_req & (ioctl_addr != r_cur_addr);
        if (w_restart) w_pk_clear = 1'b1;
`endif
    end

    fb_pixel_packer #(.THRESHOLD(THRESHOLD)) u_packer (
        .pclk    (pclk),
        .reset   (reset),
        .i_clear (w_pk_clear),
        .i_cap   (r_cap),
        .i_pix   (fb_data),
        .o_next  (w_pk_next),
        .o_done  (w_pk_done)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_k       <= 3'd0;
            r_fb_rd   <= 1'b0;
            r_cap     <= 1'b0;
            r_wait    <= 1'b0;
            r_fb_addr <= 32'd0;
            r_din     <= 8'h00;
            r_resp    <= 8'h00;
`ifdef FB_UPLOAD_PREFETCH_EN
            r_pf_run   <= 1'b0;
            r_pf_claim <= 1'b0;
            r_pf_valid <= 1'b0;
            r_pf_byte  <= 8'h00;
            r_cur_addr <= 27'd0;
`endif
        end else begin
            // fb_data answers the read issued one cycle earlier.
            r_cap <= r_fb_rd;
            case (r_state)
                S_IDLE: begin
`ifdef FB_UPLOAD_PREFETCH_EN
                    if (!ioctl_upload) r_pf_valid <= 1'b0;
`endif
                    if (w_req) begin
`ifdef FB_UPLOAD_PREFETCH_EN
                        r_pf_valid <= 1'b0;
                        r_cur_addr <= ioctl_addr;
                        if (r_pf_valid && ioctl_addr == r_cur_addr) begin
                            r_resp  <= r_pf_byte;
                            r_state <= S_RESP;
                        end else
`endif
                        if (!w_in_range) begin
                            r_resp  <= 8'h00;
                            r_state <= S_RESP;
                        end else begin
                            r_fb_addr <= w_base;
                            r_fb_rd   <= 1'b1;
                            r_k       <= 3'd0;
                            r_wait    <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_FETCH, S_DRAIN: begin
                    if (!ioctl_upload) begin
                        r_state <= S_IDLE;
                        r_fb_rd <= 1'b0;
                        r_wait  <= 1'b0;
`ifdef FB_UPLOAD_PREFETCH_EN
                        r_pf_run   <= 1'b0;
                        r_pf_claim <= 1'b0;
                        r_pf_valid <= 1'b0;
`endif
                    end else if (r_state == S_FETCH) begin
                        if (r_k == 3'd7) begin
                            r_fb_rd <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_k       <= r_k + 3'd1;
                            r_fb_addr <= r_fb_addr + 32'd1;
                        end
                    end else begin
                        r_state <= S_RESP;
`ifdef FB_UPLOAD_PREFETCH_EN
                        r_pf_run   <= 1'b0;
                        r_pf_claim <= 1'b0;
                        if (r_pf_run && !r_pf_claim && !w_claim) begin
                            r_pf_byte  <= w_pk_next;
                            r_pf_valid <= w_pk_done;
                            r_state    <= S_IDLE;
                        end else
`endif
                        // Publish while the 8th pixel is captured so the byte is out one cycle sooner.
                        if (w_pk_done) begin
                            r_resp <= w_pk_next;
                            r_din  <= w_pk_next;
                            r_wait <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    r_din   <= r_resp;
                    r_wait  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef FB_UPLOAD_PREFETCH_EN
                    if (ioctl_upload && w_next_ok) begin
                        r_cur_addr <= w_next_addr[26:0];
                        r_fb_addr  <= {2'b00, w_next_addr[26:0], 3'b000};
                        r_fb_rd    <= 1'b1;
                        r_k        <= 3'd0;
                        r_pf_run   <= 1'b1;
                        r_state    <= S_FETCH;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef FB_UPLOAD_PREFETCH_EN
            // A request landing on a speculative fetch either adopts it or replaces it.
            if (w_claim && r_state == S_FETCH) begin
                r_pf_claim <= 1'b1;
                r_wait     <= 1'b1;
            end
            if (w_restart) begin
                r_pf_run   <= 1'b0;
                r_pf_valid <= 1'b0;
                r_cap      <= 1'b0;
                r_cur_addr <= ioctl_addr;
                r_k        <= 3'd0;
                if (w_in_range) begin
                    r_fb_addr <= w_base;
                    r_fb_rd   <= 1'b1;
                    r_wait    <= 1'b1;
                    r_state   <= S_FETCH;
                end else begin
                    r_fb_rd <= 1'b0;
                    r_resp  <= 8'h00;
                    r_state <= S_RESP;
                end
            end
`endif
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign fb_rd      = r_fb_rd;
    assign fb_addr    = r_fb_addr;

endmodule

// File: tb/tb_fb_upload_packer.sv
// Bench for fb_upload_packer: three threshold builds share one ioctl stimulus, each with its own framebuffer model.
module tb_fb_upload_packer;

    logic        pclk;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [26:0] ioctl_addr;

    logic [7:0]  din_a, din_b, din_c;
    logic        wait_a, wait_b, wait_c;
    logic        rd_a, rd_b, rd_c;
    logic [31:0] addr_a, addr_b, addr_c;
    logic [7:0]  data_a, data_b, data_c;

    int checks   = 0;
    int failures = 0;
    logic [7:0] last_din_a;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];

    fb_upload_packer u_dut_a (
        .pclk(pclk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(din_a), .ioctl_wait(wait_a),
        .fb_rd(rd_a), .fb_addr(addr_a), .fb_data(data_a)
    );
    fb_upload_packer #(.THRESHOLD(8'h00)) u_dut_b (
        .pclk(pclk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(din_b), .ioctl_wait(wait_b),
        .fb_rd(rd_b), .fb_addr(addr_b), .fb_data(data_b)
    );
    fb_upload_packer #(.THRESHOLD(8'hFF)) u_dut_c (
        .pclk(pclk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(din_c), .ioctl_wait(wait_c),
        .fb_rd(rd_c), .fb_addr(addr_c), .fb_data(data_c)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [7:0] pix(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0: return 8'hFF;
            32'd1: return 8'h00;
            32'd2: return 8'hFF;
            32'd3: return 8'h00;
            32'd4: return 8'h80;
            32'd5: return 8'h7F;
            32'd6: return 8'hFF;
            32'd7: return 8'h00;
            default: begin
                h = a * 32'd2654435761;
                return h[23:16];
            end
        endcase
    endfunction

    function automatic logic [7:0] model_byte(input logic [26:0] addr, input logic [7:0] thr);
        logic [7:0]  b;
        logic [31:0] base;
        b = 8'h00;
        if ({5'd0, addr} >= 32'd38400) return 8'h00;
        base = {2'b00, addr, 3'b000};
        for (int i = 0; i < 8; i++) b[7-i] = (pix(base + 32'(i)) >= thr);
        return b;
    endfunction

    always @(posedge pclk) if (rd_a) data_a <= pix(addr_a);
    always @(posedge pclk) if (rd_b) data_b <= pix(addr_b);
    always @(posedge pclk) if (rd_c) data_c <= pix(addr_c);

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    // One request; lat = observations after the sampling edge until the byte is valid.
    task automatic do_read(input logic [26:0] addr, input int lat, input bit noise);
        logic [7:0]  e;
        logic [31:0] a_first, a_last, base;
        int          nrd, nwait, exp_nwait, exp_nrd;
        bit          fetch;
        fetch     = ({5'd0, addr} < 32'd38400) && (lat == 9);
        exp_nwait = fetch ? 9 : 0;
        exp_nrd   = fetch ? 8 : 0;
        base      = {2'b00, addr, 3'b000};
        nrd = 0; nwait = 0; a_first = 32'hFFFF_FFFF; a_last = 32'hFFFF_FFFF;
        q_a.push_back(model_byte(addr, 8'h80));
        q_b.push_back(model_byte(addr, 8'h00));
        q_c.push_back(model_byte(addr, 8'hFF));
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        @(posedge pclk); #1;
        ioctl_rd = 1'b0;
        for (int j = 0; j < 14; j++) begin
            if (j < lat) begin
                if (wait_a) nwait++;
                if (rd_a) begin
                    if (nrd == 0) a_first = addr_a;
                    a_last = addr_a;
                    nrd++;
                end
            end
            if (j == lat) begin
                e = q_a.pop_front();
                checks++;
                if (din_a !== e) begin failures++; $display("FAIL din_thr80 addr=%0d got=%h exp=%h", addr, din_a, e); end
                last_din_a = e;
                e = q_b.pop_front();
                checks++;
                if (din_b !== e) begin failures++; $display("FAIL din_thr00 addr=%0d got=%h exp=%h", addr, din_b, e); end
                e = q_c.pop_front();
                checks++;
                if (din_c !== e) begin failures++; $display("FAIL din_thrFF addr=%0d got=%h exp=%h", addr, din_c, e); end
                checks++;
                if (wait_a !== 1'b0) begin failures++; $display("FAIL wait_at_resp addr=%0d got=%b exp=0", addr, wait_a); end
            end
            if (noise && j >= 1 && j <= 4) begin
                ioctl_rd = 1'b1; ioctl_addr = 27'd999;
            end else begin
                ioctl_rd = 1'b0; ioctl_addr = addr;
            end
            @(posedge pclk); #1;
        end
        checks++;
        if (nwait != exp_nwait) begin failures++; $display("FAIL wait_cycles addr=%0d got=%0d exp=%0d", addr, nwait, exp_nwait); end
        checks++;
        if (nrd != exp_nrd) begin failures++; $display("FAIL fb_rd_cycles addr=%0d got=%0d exp=%0d", addr, nrd, exp_nrd); end
        if (exp_nrd != 0) begin
            checks++;
            if (a_first !== base) begin failures++; $display("FAIL fb_addr_first addr=%0d got=%0d exp=%0d", addr, a_first, base); end
            checks++;
            if (a_last !== base + 32'd7) begin failures++; $display("FAIL fb_addr_last addr=%0d got=%0d exp=%0d", addr, a_last, base + 32'd7); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++;
        if (din_a !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", din_a); end
        checks++;
        if (wait_a !== 1'b0) begin failures++; $display("FAIL reset_wait got=%b exp=0", wait_a); end
        checks++;
        if (rd_a !== 1'b0) begin failures++; $display("FAIL reset_fb_rd got=%b exp=0", rd_a); end
        checks++;
        if (addr_a !== 32'd0) begin failures++; $display("FAIL reset_fb_addr got=%0d exp=0", addr_a); end
        reset = 1'b0;
        last_din_a = 8'h00;
        idle(2);
    endtask

    task automatic test_basic();
        do_read(27'd0, 9, 1'b0);
        idle(12);
    endtask

    task automatic test_boundary();
        do_read(27'd38399, 9, 1'b0);
        idle(12);
        do_read(27'd38400, 1, 1'b0);
        idle(4);
        do_read(27'h7FF_FFFF, 1, 1'b0);
        idle(4);
    endtask

    task automatic test_patterns();
        logic [26:0] list [3];
        list[0] = 27'd1234; list[1] = 27'd20000; list[2] = 27'd38000;
        for (int i = 0; i < 3; i++) begin
            do_read(list[i], 9, 1'b0);
            idle(12);
        end
    endtask

    task automatic test_rd_without_upload();
        ioctl_upload = 1'b0;
        ioctl_addr = 27'd3;
        ioctl_rd = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge pclk); #1;
            checks++;
            if (wait_a !== 1'b0 || rd_a !== 1'b0 || din_a !== last_din_a) begin
                failures++;
                $display("FAIL rd_no_upload wait=%b fb_rd=%b din=%h exp wait=0 fb_rd=0 din=%h", wait_a, rd_a, din_a, last_din_a);
            end
        end
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b1;
        idle(2);
    endtask

    task automatic test_extra_rd();
        do_read(27'd3, 9, 1'b1);
        idle(12);
    endtask

    task automatic test_abort();
        ioctl_addr = 27'd5;
        ioctl_rd = 1'b1;
        @(posedge pclk); #1;
        ioctl_rd = 1'b0;
        idle(3);
        checks++;
        if (wait_a !== 1'b1) begin failures++; $display("FAIL abort_prefetch_busy wait got=%b exp=1", wait_a); end
        ioctl_upload = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if (rd_a !== 1'b0) begin failures++; $display("FAIL abort_fb_rd got=%b exp=0", rd_a); end
        checks++;
        if (wait_a !== 1'b0) begin failures++; $display("FAIL abort_wait got=%b exp=0", wait_a); end
        checks++;
        if (din_a !== last_din_a) begin failures++; $display("FAIL abort_din got=%h exp=%h", din_a, last_din_a); end
        idle(3);
        checks++;
        if (rd_a !== 1'b0 || wait_a !== 1'b0) begin failures++; $display("FAIL abort_idle fb_rd=%b wait=%b exp 0 0", rd_a, wait_a); end
        ioctl_upload = 1'b1;
        idle(3);
        do_read(27'd5, 9, 1'b0);
        idle(12);
    endtask

    task automatic test_reset_mid();
        ioctl_addr = 27'd7;
        ioctl_rd = 1'b1;
        @(posedge pclk); #1;
        ioctl_rd = 1'b0;
        idle(5);
        reset = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if (din_a !== 8'h00) begin failures++; $display("FAIL midreset_din got=%h exp=00", din_a); end
        checks++;
        if (wait_a !== 1'b0) begin failures++; $display("FAIL midreset_wait got=%b exp=0", wait_a); end
        checks++;
        if (rd_a !== 1'b0) begin failures++; $display("FAIL midreset_fb_rd got=%b exp=0", rd_a); end
        checks++;
        if (addr_a !== 32'd0) begin failures++; $display("FAIL midreset_fb_addr got=%0d exp=0", addr_a); end
        reset = 1'b0;
        last_din_a = 8'h00;
        idle(3);
        do_read(27'd7, 9, 1'b0);
        idle(12);
    endtask

    task automatic test_sequential();
`ifdef FB_UPLOAD_PREFETCH_EN
        do_read(27'd0, 9, 1'b0);
        idle(20);
        do_read(27'd1, 1, 1'b0);
        idle(20);
        do_read(27'd2, 1, 1'b0);
        idle(20);
        do_read(27'd100, 9, 1'b0);
        idle(20);
`else
        do_read(27'd0, 9, 1'b0);
        idle(20);
        do_read(27'd1, 9, 1'b0);
        idle(20);
        do_read(27'd2, 9, 1'b0);
        idle(12);
`endif
    endtask

    initial begin
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 27'd0;
        last_din_a   = 8'h00;
        #1;
        test_reset();
        ioctl_upload = 1'b1;
        idle(2);
        test_basic();
        test_boundary();
        test_patterns();
        test_rd_without_upload();
        test_extra_rd();
        test_abort();
        test_reset_mid();
        test_sequential();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
